// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between the fetch (IF) and
// data (MEM) requesters. Data has priority. A starvation counter lets
// fetch win a simultaneous request after STARVE_MAX data grants made while
// fetch was waiting. The winning command is latched and held on the memory
// port until m_done. On m_done the other side may be granted directly.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    // fetch requester
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    // data requester
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    // unified memory
    output logic        m_rd,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    input  logic [15:0] m_data_out,
    input  logic        m_done,
    // sticky protocol error
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_r;
    logic [15:0] addr_r;
    logic [15:0] data_r;
    logic        op_rd_r;
    logic        op_wr_r;
    logic [3:0]  starve_r;
    logic        err_r;

    logic        i_req_s;
    logic        d_req_s;
    logic        grant_i_s;
    logic        grant_d_s;
    logic        busy_s;
    logic        err_set_s;

    assign i_req_s = i_rd;
    assign d_req_s = d_rd | d_wr;
    assign busy_s  = (state_r == IBUSY) || (state_r == DBUSY);

    // Grant decision: full arbitration in IDLE, hand-over to the other side on m_done
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req_s && !(i_req_s && (starve_r == STARVE_LIM))) begin
                    grant_d_s = 1'b1;
                end else if (i_req_s) begin
                    grant_i_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                end
            end
            IBUSY: begin
                // the completing fetch still holds i_rd, so only data is considered
                if (m_done && d_req_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_d_s = 1'b0;
                end
            end
            DBUSY: begin
                // the completing data request is excluded, only fetch is considered
                if (m_done && i_req_s) begin
                    grant_i_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                end
            end
            default: begin
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
            end
        endcase
    end

    // Error conditions: conflicting data ops, stray m_done, or the granted side dropping early
    always_comb begin
        err_set_s = 1'b0;
        if (d_rd && d_wr) begin
            err_set_s = 1'b1;
        end else if ((state_r == IDLE) && m_done) begin
            err_set_s = 1'b1;
        end else if ((state_r == IBUSY) && !i_req_s && !m_done) begin
            err_set_s = 1'b1;
        end else if ((state_r == DBUSY) && !d_req_s && !m_done) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Grant FSM and command latch; a rd+wr data request is executed as a read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= 16'd0;
            data_r  <= 16'd0;
            op_rd_r <= 1'b0;
            op_wr_r <= 1'b0;
        end else if (grant_d_s) begin
            state_r <= DBUSY;
            addr_r  <= d_addr;
            data_r  <= d_data_in;
            op_rd_r <= d_rd;
            op_wr_r <= d_wr & ~d_rd;
        end else if (grant_i_s) begin
            state_r <= IBUSY;
            addr_r  <= i_addr;
            data_r  <= 16'd0;
            op_rd_r <= 1'b1;
            op_wr_r <= 1'b0;
        end else if (busy_s && m_done) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_r;
        end
    end

    // Starvation counter: counts data grants made over a waiting fetch, cleared by a fetch grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r <= 4'd0;
        end else if (grant_i_s) begin
            starve_r <= 4'd0;
        end else if (grant_d_s && i_req_s && (starve_r < STARVE_LIM)) begin
            starve_r <= starve_r + 4'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Memory port is driven only while a grant is outstanding
    assign m_rd      = (state_r == IBUSY) | ((state_r == DBUSY) & op_rd_r);
    assign m_wr      = (state_r == DBUSY) & op_wr_r;
    assign m_addr    = busy_s ? addr_r : 16'd0;
    assign m_data_in = busy_s ? data_r : 16'd0;

    // Completion routed to the granted side in the m_done cycle
    assign i_done     = (state_r == IBUSY) & m_done;
    assign d_done     = (state_r == DBUSY) & m_done;
    assign i_data_out = i_done ? m_data_out : 16'd0;
    assign d_data_out = d_done ? m_data_out : 16'd0;

    assign i_stall = i_req_s & ~i_done;
    assign d_stall = d_req_s & ~d_done;
    assign err     = err_r;

endmodule
